multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM for the multicycle variant of the RV32I core.
- Sequences a shared-memory datapath (PC, IR, OldPC, A/B/ALUOut/Data registers) through fetch, decode, execute, memory and writeback steps.
- Generates per-state datapath selects, ALU control and byte-lane write enables, and waits on a memory ready handshake.
- Traps on illegal opcodes or misaligned stores/loads.
- Sits beside the multicycle datapath; drives its control inputs and the unified memory port.

Parameters:
- RESET_STATE, 4'd0, state entered at reset (FETCH); not intended to be overridden except in test.
- INSTRET_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- op  input  7  Instr[6:0] from IR
- funct3  input  3  Instr[14:12]
- funct7b5  input  1  Instr[30]
- zero  input  1  ALU zero flag
- adr_lo  input  2  ALUResult[1:0] (effective address low bits)
- mem_ready  input  1  memory completes current access this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  0=PC, 1=Result
- MemWrite  output  1  memory write strobe
- MemWriteByte  output  4  byte-lane write enables
- IRWrite  output  1  IR and OldPC enable
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  output  2  00 RD2, 01 ImmExt, 10 const 4
- ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
- ALUControl  output  4  ALU operation code
- RegWrite  output  1  register file write enable
- trap  output  1  sticky illegal/misaligned flag
- instret  output  INSTRET_W  retired-instruction count

Behaviour:
- States (4-bit):
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, TRAP=15.
- Reset (reset=0, asynchronous):
  - state=FETCH, trap=0, instret=0.
  - Every enable (PCWrite, IRWrite, MemWrite, RegWrite, MemWriteByte) is forced 0 while reset is low.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stay while !mem_ready; go to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ImmSrc=10, ALUControl=ADD (branch target into ALUOut).
  - Next state by op:
    - 0000011 and 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BRANCH
    - otherwise TRAP
- MEMADR:
  - ALUSrcA=10, ALUSrcB=01, ALUControl=ADD; ImmSrc=01 for stores, 00 for loads.
  - Misaligned access -> TRAP: halfword (funct3[1:0]=01) with adr_lo[0]=1, or word (10) with adr_lo!=00.
  - Otherwise load -> MEMREAD, store -> MEMWRITE.
- MEMREAD:
  - AdrSrc=1, ResultSrc=00.
  - Waits for mem_ready, then -> MEMWB.
- MEMWB:
  - ResultSrc=01, RegWrite=1 -> FETCH; retires.
- MEMWRITE:
  - AdrSrc=1, ResultSrc=00, MemWrite=1 for every cycle in the state.
  - MemWriteByte, using the adr_lo value registered in MEMADR:
    - sb: 4'b0001<<adr_lo
    - sh: 4'b0011<<{adr_lo[1],1'b0}
    - sw: 4'b1111
  - Holds until mem_ready, then -> FETCH; retires.
- EXECR / EXECI:
  - ALUSrcA=10; ALUSrcB=00 (R) / 01 (I), ImmSrc=00.
  - Next state ALUWB.
- ALUControl decode by funct3 (R/I):
  - 000: ADD 0000, or SUB 0001 when R-type and funct7b5=1
  - 001: SLL 0110
  - 010: SLT 0101
  - 011: SLTU 1001
  - 100: XOR 0100
  - 101: SRL 0111, or SRA 1000 when funct7b5=1
  - 110: OR 0011
  - 111: AND 0010
  - I-type ignores funct7b5 except for funct3=101.
- ALUWB:
  - ResultSrc=00, RegWrite=1 -> FETCH; retires.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, ResultSrc=00, ALUControl=ADD, PCWrite=1 (PC<=ALUOut target) -> ALUWB.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, ALUControl=SUB, ResultSrc=00.
  - PCWrite = zero XOR funct3[0] (beq/bne); other funct3 -> TRAP.
  - -> FETCH; retires.
- TRAP:
  - All enables 0, trap=1; stays until reset.
- Retirement: instret increments by 1 (wrapping modulo 2^INSTRET_W) on each exit to FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
- Default outputs in every state not listed above: selects 0, enables 0.
- Reset asserted mid-access (MEMWRITE) drops MemWrite immediately; there is no partial-retire count.

Test Plan:
- `add x3,x1,x2`, mem_ready=1 -> states 0,1,6,7,0; RegWrite=1 only in ALUWB; ALUControl=0000; instret 0->1.
- `sub` (funct7b5=1) and `srai` (funct3=101, funct7b5=1) -> ALUControl 0001 and 1000 respectively.
- `sb` at adr_lo=2'b10 with mem_ready low 3 cycles -> MEMWRITE held 4 cycles, MemWriteByte=0100 throughout, then FETCH.
- `lw` at adr_lo=2'b01 -> MEMADR->TRAP, trap=1, no RegWrite, instret unchanged; further cycles stay TRAP.
- `bne` with zero=0 -> PCWrite=1 in BRANCH; `beq` with zero=0 -> PCWrite=0.
- Assert reset low during MEMWRITE -> MemWrite=0 asynchronously, state=FETCH, instret=0 after release.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: one state per cycle, outputs decoded from state.
// FETCH and MEMREAD wait on mem_ready; MEMWRITE holds its strobe until mem_ready completes the store.
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter int         INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic [1:0]           adr_lo,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic [3:0]           MemWriteByte,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [3:0]           ALUControl,
    output logic                 RegWrite,
    output logic                 trap,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BRANCH   = 4'd10,
        TRAP     = 4'd15
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    state_t                 state_q, state_d;
    logic [1:0]             adr_lo_q, adr_lo_d;
    logic                   trap_q;
    logic [INSTRET_W-1:0]   instret_q;
    logic                   retire;
    logic                   misaligned;

    logic                   pc_write_c, mem_write_c, ir_write_c, reg_write_c;
    logic [3:0]             mem_byte_c;

    // funct7b5 only selects SUB for R-type; shifts honour it for both forms.
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7b5, input logic rtype);
        logic [3:0] r;
        case (f3)
            3'b000:  r = (rtype && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    always_comb begin
        misaligned = ((funct3[1:0] == 2'b01) && adr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (adr_lo != 2'b00));
    end

    always_comb begin
        state_d     = state_q;
        adr_lo_d    = adr_lo_q;
        retire      = 1'b0;
        pc_write_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_byte_c  = 4'b0000;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ImmSrc      = 2'b00;
        ALUControl  = ALU_ADD;

        case (state_q)
            FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
                case (op)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:              state_d = EXECR;
                    OP_I:              state_d = EXECI;
                    OP_JAL:            state_d = JAL;
                    OP_BR:             state_d = BRANCH;
                    default:           state_d = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                ImmSrc   = (op == OP_STORE) ? 2'b01 : 2'b00;
                adr_lo_d = adr_lo;
                if (misaligned)          state_d = TRAP;
                else if (op == OP_STORE) state_d = MEMWRITE;
                else                     state_d = MEMREAD;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_c = 1'b1;
                // Lane select uses the address captured in MEMADR; ALUResult has moved on.
                case (funct3[1:0])
                    2'b00:   mem_byte_c = 4'b0001 << adr_lo_q;
                    2'b01:   mem_byte_c = 4'b0011 << {adr_lo_q[1], 1'b0};
                    default: mem_byte_c = 4'b1111;
                endcase
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec(funct3, funct7b5, 1'b1);
                state_d    = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec(funct3, funct7b5, 1'b0);
                state_d    = ALUWB;
            end
            ALUWB: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write_c = 1'b1;
                state_d    = ALUWB;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                if (funct3[2:1] == 2'b00) begin
                    pc_write_c = zero ^ funct3[0];
                    retire     = 1'b1;
                    state_d    = FETCH;
                end else begin
                    state_d = TRAP;
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = TRAP;
            end
        endcase
    end

    // Enables are qualified by reset so nothing strobes while the async reset is held.
    assign PCWrite      = pc_write_c  & reset;
    assign MemWrite     = mem_write_c & reset;
    assign IRWrite      = ir_write_c  & reset;
    assign RegWrite     = reg_write_c & reset;
    assign MemWriteByte = mem_byte_c & {4{reset}};
    assign trap         = trap_q;
    assign instret      = instret_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= state_t'(RESET_STATE);
            adr_lo_q  <= 2'b00;
            trap_q    <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q  <= state_d;
            adr_lo_q <= adr_lo_d;
            if (state_d == TRAP) trap_q <= 1'b1;
            if (retire)          instret_q <= instret_q + INSTRET_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed vector bench for multicycle_controller: per-cycle input/expected-output table,
// plus a hand sequence for asynchronous reset during a store.
module tb_multicycle_controller;

    localparam logic [6:0] R_T = 7'b0110011;
    localparam logic [6:0] I_T = 7'b0010011;
    localparam logic [6:0] L_T = 7'b0000011;
    localparam logic [6:0] S_T = 7'b0100011;
    localparam logic [6:0] J_T = 7'b1101111;
    localparam logic [6:0] B_T = 7'b1100011;
    localparam logic [6:0] X_T = 7'b1111111;

    logic        clk;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic [1:0]  adr_lo;
    logic        mem_ready;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, trap;
    logic [3:0]  MemWriteByte, ALUControl;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [31:0] instret;

    typedef struct packed {
        logic        pcw;
        logic        adr;
        logic        mw;
        logic [3:0]  mwb;
        logic        irw;
        logic [1:0]  rs;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [1:0]  imm;
        logic [3:0]  alu;
        logic        rw;
        logic        tr;
        logic [31:0] ir;
    } out_t;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic [1:0] a;
        logic       rdy;
        out_t       e;
    } vec_t;

    vec_t vecs[$];
    int   n_chk;
    int   n_fail;

    multicycle_controller #(.RESET_STATE(4'd0), .INSTRET_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .adr_lo(adr_lo), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .MemWriteByte(MemWriteByte),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite), .trap(trap),
        .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t o(input logic pcw, input logic adr, input logic mw, input logic [3:0] mwb,
                               input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                               input logic [1:0] sb, input logic [1:0] imm, input logic [3:0] alu,
                               input logic rw, input logic tr, input logic [31:0] ir);
        return '{pcw, adr, mw, mwb, irw, rs, sa, sb, imm, alu, rw, tr, ir};
    endfunction

    // Expected outputs for each controller state, written out by hand.
    function automatic out_t erst();
        return o(0, 0, 0, 4'h0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0000, 0, 0, 0);
    endfunction
    function automatic out_t ef(input logic r, input logic [31:0] ir);
        return o(r, 0, 0, 4'h0, r, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0000, 0, 0, ir);
    endfunction
    function automatic out_t ed(input logic [31:0] ir);
        return o(0, 0, 0, 4'h0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 4'b0000, 0, 0, ir);
    endfunction
    function automatic out_t er(input logic [3:0] alu, input logic [31:0] ir);
        return o(0, 0, 0, 4'h0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 0, 0, ir);
    endfunction
    function automatic out_t ei(input logic [3:0] alu, input logic [31:0] ir);
        return o(0, 0, 0, 4'h0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 0, 0, ir);
    endfunction
    function automatic out_t ewb(input logic [31:0] ir);
        return o(0, 0, 0, 4'h0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1, 0, ir);
    endfunction
    function automatic out_t ej(input logic [31:0] ir);
        return o(1, 0, 0, 4'h0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 4'b0000, 0, 0, ir);
    endfunction
    function automatic out_t eb(input logic p, input logic [31:0] ir);
        return o(p, 0, 0, 4'h0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0001, 0, 0, ir);
    endfunction
    function automatic out_t ema(input logic [1:0] imm, input logic [31:0] ir);
        return o(0, 0, 0, 4'h0, 0, 2'b00, 2'b10, 2'b01, imm, 4'b0000, 0, 0, ir);
    endfunction
    function automatic out_t emr(input logic [31:0] ir);
        return o(0, 1, 0, 4'h0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 0, ir);
    endfunction
    function automatic out_t emwb(input logic [31:0] ir);
        return o(0, 0, 0, 4'h0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 1, 0, ir);
    endfunction
    function automatic out_t emw(input logic [3:0] mwb, input logic [31:0] ir);
        return o(0, 1, 1, mwb, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 0, ir);
    endfunction
    function automatic out_t etr(input logic [31:0] ir);
        return o(0, 0, 0, 4'h0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 1, ir);
    endfunction

    task automatic av(input logic rst, input logic [6:0] vop, input logic [2:0] f3, input logic f7,
                      input logic z, input logic [1:0] a, input logic rdy, input out_t e);
        vec_t v;
        v.rst = rst; v.op = vop; v.f3 = f3; v.f7 = f7; v.z = z; v.a = a; v.rdy = rdy; v.e = e;
        vecs.push_back(v);
    endtask

    function automatic out_t actual();
        return {PCWrite, AdrSrc, MemWrite, MemWriteByte, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, ALUControl, RegWrite, trap, instret};
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = actual();
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; op = R_T; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        adr_lo = 2'd0; mem_ready = 1'b1;
        n_chk = 0; n_fail = 0;

        av(0, R_T, 3'd0, 0, 0, 2'd0, 1, erst());
        // add x3,x1,x2
        av(1, R_T, 3'd0, 0, 0, 2'd0, 1, ef(1, 0));
        av(1, R_T, 3'd0, 0, 0, 2'd0, 1, ed(0));
        av(1, R_T, 3'd0, 0, 0, 2'd0, 1, er(4'b0000, 0));
        av(1, R_T, 3'd0, 0, 0, 2'd0, 1, ewb(0));
        // sub
        av(1, R_T, 3'd0, 1, 0, 2'd0, 1, ef(1, 1));
        av(1, R_T, 3'd0, 1, 0, 2'd0, 1, ed(1));
        av(1, R_T, 3'd0, 1, 0, 2'd0, 1, er(4'b0001, 1));
        av(1, R_T, 3'd0, 1, 0, 2'd0, 1, ewb(1));
        // srai
        av(1, I_T, 3'd5, 1, 0, 2'd0, 1, ef(1, 2));
        av(1, I_T, 3'd5, 1, 0, 2'd0, 1, ed(2));
        av(1, I_T, 3'd5, 1, 0, 2'd0, 1, ei(4'b1000, 2));
        av(1, I_T, 3'd5, 1, 0, 2'd0, 1, ewb(2));
        // addi with Instr[30] set stays ADD
        av(1, I_T, 3'd0, 1, 0, 2'd0, 1, ef(1, 3));
        av(1, I_T, 3'd0, 1, 0, 2'd0, 1, ed(3));
        av(1, I_T, 3'd0, 1, 0, 2'd0, 1, ei(4'b0000, 3));
        av(1, I_T, 3'd0, 1, 0, 2'd0, 1, ewb(3));
        // or
        av(1, R_T, 3'd6, 0, 0, 2'd0, 1, ef(1, 4));
        av(1, R_T, 3'd6, 0, 0, 2'd0, 1, ed(4));
        av(1, R_T, 3'd6, 0, 0, 2'd0, 1, er(4'b0011, 4));
        av(1, R_T, 3'd6, 0, 0, 2'd0, 1, ewb(4));
        // jal
        av(1, J_T, 3'd0, 0, 0, 2'd0, 1, ef(1, 5));
        av(1, J_T, 3'd0, 0, 0, 2'd0, 1, ed(5));
        av(1, J_T, 3'd0, 0, 0, 2'd0, 1, ej(5));
        av(1, J_T, 3'd0, 0, 0, 2'd0, 1, ewb(5));
        // bne zero=0 taken, beq zero=0 not taken
        av(1, B_T, 3'd1, 0, 0, 2'd0, 1, ef(1, 6));
        av(1, B_T, 3'd1, 0, 0, 2'd0, 1, ed(6));
        av(1, B_T, 3'd1, 0, 0, 2'd0, 1, eb(1, 6));
        av(1, B_T, 3'd0, 0, 0, 2'd0, 1, ef(1, 7));
        av(1, B_T, 3'd0, 0, 0, 2'd0, 1, ed(7));
        av(1, B_T, 3'd0, 0, 0, 2'd0, 1, eb(0, 7));
        // fetch stall, then sb at adr_lo=10 with 3 not-ready cycles in MEMWRITE
        av(1, S_T, 3'd0, 0, 0, 2'd2, 0, ef(0, 8));
        av(1, S_T, 3'd0, 0, 0, 2'd2, 1, ef(1, 8));
        av(1, S_T, 3'd0, 0, 0, 2'd2, 1, ed(8));
        av(1, S_T, 3'd0, 0, 0, 2'd2, 1, ema(2'b01, 8));
        av(1, S_T, 3'd0, 0, 0, 2'd0, 0, emw(4'b0100, 8));
        av(1, S_T, 3'd0, 0, 0, 2'd0, 0, emw(4'b0100, 8));
        av(1, S_T, 3'd0, 0, 0, 2'd0, 0, emw(4'b0100, 8));
        av(1, S_T, 3'd0, 0, 0, 2'd0, 1, emw(4'b0100, 8));
        // misaligned lw traps and sticks
        av(1, L_T, 3'd2, 0, 0, 2'd1, 1, ef(1, 9));
        av(1, L_T, 3'd2, 0, 0, 2'd1, 1, ed(9));
        av(1, L_T, 3'd2, 0, 0, 2'd1, 1, ema(2'b00, 9));
        av(1, L_T, 3'd2, 0, 0, 2'd1, 1, etr(9));
        av(1, R_T, 3'd0, 0, 0, 2'd0, 1, etr(9));
        // illegal opcode
        av(0, X_T, 3'd0, 0, 0, 2'd0, 1, erst());
        av(1, X_T, 3'd0, 0, 0, 2'd0, 1, ef(1, 0));
        av(1, X_T, 3'd0, 0, 0, 2'd0, 1, ed(0));
        av(1, X_T, 3'd0, 0, 0, 2'd0, 1, etr(0));
        // aligned lw with one memory wait
        av(0, L_T, 3'd2, 0, 0, 2'd0, 1, erst());
        av(1, L_T, 3'd2, 0, 0, 2'd0, 1, ef(1, 0));
        av(1, L_T, 3'd2, 0, 0, 2'd0, 1, ed(0));
        av(1, L_T, 3'd2, 0, 0, 2'd0, 1, ema(2'b00, 0));
        av(1, L_T, 3'd2, 0, 0, 2'd0, 0, emr(0));
        av(1, L_T, 3'd2, 0, 0, 2'd0, 1, emr(0));
        av(1, L_T, 3'd2, 0, 0, 2'd0, 1, emwb(0));
        // sh at adr_lo=10
        av(1, S_T, 3'd1, 0, 0, 2'd2, 1, ef(1, 1));
        av(1, S_T, 3'd1, 0, 0, 2'd2, 1, ed(1));
        av(1, S_T, 3'd1, 0, 0, 2'd2, 1, ema(2'b01, 1));
        av(1, S_T, 3'd1, 0, 0, 2'd2, 1, emw(4'b1100, 1));
        // sw, left stalled in MEMWRITE for the reset sequence below
        av(1, S_T, 3'd2, 0, 0, 2'd0, 1, ef(1, 2));
        av(1, S_T, 3'd2, 0, 0, 2'd0, 1, ed(2));
        av(1, S_T, 3'd2, 0, 0, 2'd0, 1, ema(2'b01, 2));
        av(1, S_T, 3'd2, 0, 0, 2'd0, 0, emw(4'b1111, 2));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; op = vecs[i].op; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7;
            zero = vecs[i].z; adr_lo = vecs[i].a; mem_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d", i), vecs[i].e);
        end

        // Reset mid-store: strobes and counter drop without waiting for a clock edge.
        #1 reset = 1'b0;
        #1 check("async_rst_memwrite", erst());
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0;
        #1 check("post_rst_fetch", ef(0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
